// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Requester-side and RAM-side signal bundle of mem_port_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            i_req;
    logic [NUM_REQ-1:0]            i_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] i_wdata;
    logic [NUM_REQ-1:0]            o_gnt;
    logic                          o_mem_en;
    logic                          o_mem_we;
    logic [ADDR_WIDTH-1:0]         o_mem_addr;
    logic [DATA_WIDTH-1:0]         o_mem_din;
    logic [DATA_WIDTH-1:0]         i_mem_dout;
    logic                          o_rvalid;
    logic [ID_W-1:0]               o_rid;
    logic [DATA_WIDTH-1:0]         o_rdata;
    logic                          o_busy;

    modport slave (
        input  i_req, i_we, i_addr, i_wdata, i_mem_dout,
        output o_gnt, o_mem_en, o_mem_we, o_mem_addr, o_mem_din,
        output o_rvalid, o_rid, o_rdata, o_busy
    );

    modport master (
        output i_req, i_we, i_addr, i_wdata, i_mem_dout,
        input  o_gnt, o_mem_en, o_mem_we, o_mem_addr, o_mem_din,
        input  o_rvalid, o_rid, o_rdata, o_busy
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Round-robin arbiter sharing one RAM port between NUM_REQ
//                requesters, with a tag pipeline returning id-tagged reads.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int RD_LATENCY = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    mem_port_arbiter_if.slave bus
);
    localparam int              ID_W      = $clog2(NUM_REQ);
    localparam logic [ID_W:0]   c_num_req = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] c_last_id = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]       r_ptr;
    logic [ADDR_WIDTH-1:0] w_addr_lane  [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_wdata_lane [NUM_REQ];
    logic [NUM_REQ-1:0]    w_gnt;
    logic [ID_W-1:0]       w_gnt_id;
    logic                  w_accept;
    logic [ID_W:0]         w_scan;

    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_din;
    logic [ID_W-1:0]       r_issue_id;

    logic [RD_LATENCY-1:0] r_tag_vld;
    logic [RD_LATENCY-1:0] w_tag_vld_next;
    logic [ID_W-1:0]       r_tag_id [RD_LATENCY];
    logic                  r_busy;

    logic                  r_rvalid;
    logic [ID_W-1:0]       r_rid;
    logic [DATA_WIDTH-1:0] r_rdata;

    generate
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
            assign w_addr_lane[k]  = bus.i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdata_lane[k] = bus.i_wdata[k*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Scan from the pointer upward with wrap; first requester found wins.
    always_comb begin
        w_gnt    = '0;
        w_gnt_id = '0;
        w_accept = 1'b0;
        w_scan   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_scan = {1'b0, r_ptr} + (ID_W+1)'(i);
            if (w_scan >= c_num_req) begin
                w_scan = w_scan - c_num_req;
            end
            if (!w_accept && bus.i_req[w_scan[ID_W-1:0]]) begin
                w_accept = 1'b1;
                w_gnt_id = w_scan[ID_W-1:0];
            end
        end
        if (i_rst) begin
            w_accept = 1'b0;
        end
        if (w_accept) begin
            w_gnt[w_gnt_id] = 1'b1;
        end
    end

    // Stage 0 captures what the RAM port is doing this cycle.
    always_comb begin
        w_tag_vld_next    = '0;
        w_tag_vld_next[0] = r_mem_en & ~r_mem_we;
        for (int s = 1; s < RD_LATENCY; s++) begin
            w_tag_vld_next[s] = r_tag_vld[s-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr      <= '0;
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_issue_id <= '0;
            r_tag_vld  <= '0;
            for (int s = 0; s < RD_LATENCY; s++) begin
                r_tag_id[s] <= '0;
            end
            r_busy     <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rid      <= '0;
            r_rdata    <= '0;
        end else begin
            r_mem_en <= w_accept;
            r_mem_we <= w_accept & bus.i_we[w_gnt_id];
            if (w_accept) begin
                r_ptr      <= (w_gnt_id == c_last_id) ? '0 : w_gnt_id + ID_W'(1);
                r_mem_addr <= w_addr_lane[w_gnt_id];
                r_mem_din  <= w_wdata_lane[w_gnt_id];
                r_issue_id <= w_gnt_id;
            end

            r_tag_vld   <= w_tag_vld_next;
            r_tag_id[0] <= r_issue_id;
            for (int s = 1; s < RD_LATENCY; s++) begin
                r_tag_id[s] <= r_tag_id[s-1];
            end
            r_busy <= |w_tag_vld_next;

            r_rvalid <= r_tag_vld[RD_LATENCY-1];
            if (r_tag_vld[RD_LATENCY-1]) begin
                r_rid   <= r_tag_id[RD_LATENCY-1];
                r_rdata <= bus.i_mem_dout;
            end
        end
    end

    assign bus.o_gnt      = w_gnt;
    assign bus.o_mem_en   = r_mem_en;
    assign bus.o_mem_we   = r_mem_we;
    assign bus.o_mem_addr = r_mem_addr;
    assign bus.o_mem_din  = r_mem_din;
    assign bus.o_rvalid   = r_rvalid;
    assign bus.o_rid      = r_rid;
    assign bus.o_rdata    = r_rdata;
    assign bus.o_busy     = r_busy;
endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Scoreboard bench for mem_port_arbiter with a behavioural RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;
    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int AW  = 6;
    localparam int RDL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_port_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RDL)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    // Behavioural RAM: writes land at the issue edge, reads appear RDL cycles after issue.
    logic [DW-1:0] ram [0:63];
    logic [DW-1:0] rd_pipe [RDL];
    always @(posedge clk) begin
        if (bus.o_mem_en === 1'b1) begin
            if (bus.o_mem_we) ram[bus.o_mem_addr] <= bus.o_mem_din;
            else              rd_pipe[0] <= ram[bus.o_mem_addr];
        end
        for (int s = 1; s < RDL; s++) rd_pipe[s] <= rd_pipe[s-1];
    end
    assign bus.i_mem_dout = rd_pipe[RDL-1];

    typedef struct { int cyc; bit we; logic [AW-1:0] addr; logic [DW-1:0] din; } iss_t;
    typedef struct { int cyc; int id; logic [DW-1:0] data; } rsp_t;
    iss_t iq[$];
    rsp_t rq[$];
    bit   busy_exp [0:8191];

    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;
    logic [N-1:0]  exp_gnt = '0;
    bit            done = 1'b0;
    bit            prev_rst = 1'b1;
    int            rr = 0;
    bit            pend [N];
    bit            p_we [N];
    logic [AW-1:0] p_addr [N];
    logic [DW-1:0] p_din [N];
    logic [DW-1:0] ref_mem [0:63];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_req(input int k, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[k]   = 1'b1;
        p_we[k]   = we;
        p_addr[k] = a;
        p_din[k]  = d;
    endtask

    // Reference: acceptance pushes the issue expectation and, for reads, the response.
    task automatic accept(input int k);
        iq.push_back('{cyc + 1, p_we[k], p_addr[k], p_din[k]});
        if (p_we[k]) begin
            ref_mem[p_addr[k]] = p_din[k];
        end else begin
            rq.push_back('{cyc + RDL + 2, k, ref_mem[p_addr[k]]});
            for (int d = 2; d <= RDL + 1; d++) busy_exp[cyc + d] = 1'b1;
        end
        rr      = (k + 1) % N;
        pend[k] = 1'b0;
    endtask

    task automatic purge(input int r);
        while (iq.size() > 0 && iq[$].cyc > r) void'(iq.pop_back());
        while (rq.size() > 0 && rq[$].cyc > r) void'(rq.pop_back());
        for (int c = r + 1; c <= r + RDL + 2; c++) busy_exp[c] = 1'b0;
    endtask

    task automatic drive_cycle(input bit rst_v);
        bit found;
        @(posedge clk);
        #1;
        cyc++;
        rst = rst_v;
        for (int k = 0; k < N; k++) begin
            bus.i_req[k] = pend[k];
            bus.i_we[k]  = pend[k] ? p_we[k] : 1'($urandom);
            bus.i_addr[k*AW +: AW]  = pend[k] ? p_addr[k] : AW'($urandom);
            bus.i_wdata[k*DW +: DW] = pend[k] ? p_din[k]  : DW'($urandom);
        end
        exp_gnt = '0;
        if (rst_v) begin
            purge(cyc);
            rr = 0;
        end else begin
            found = 1'b0;
            for (int i = 0; i < N; i++) begin
                int k;
                k = (rr + i) % N;
                if (!found && pend[k]) begin
                    found      = 1'b1;
                    exp_gnt[k] = 1'b1;
                    accept(k);
                end
            end
        end
    endtask

    // Monitor: compares DUT outputs with the scoreboard queues each cycle.
    always @(negedge clk) begin
        if (cyc >= 1 && !done) begin
            chk("gnt", 32'(bus.o_gnt), 32'(exp_gnt));
            if (cyc >= 2) begin
                if (iq.size() > 0 && iq[0].cyc == cyc) begin
                    chk("mem_en", 32'(bus.o_mem_en), 32'd1);
                    chk("mem_we", 32'(bus.o_mem_we), 32'(iq[0].we));
                    chk("mem_addr", 32'(bus.o_mem_addr), 32'(iq[0].addr));
                    if (iq[0].we) chk("mem_din", 32'(bus.o_mem_din), 32'(iq[0].din));
                    void'(iq.pop_front());
                end else begin
                    chk("mem_en_idle", 32'(bus.o_mem_en), 32'd0);
                    chk("mem_we_idle", 32'(bus.o_mem_we), 32'd0);
                end
                if (rq.size() > 0 && rq[0].cyc == cyc) begin
                    chk("rvalid", 32'(bus.o_rvalid), 32'd1);
                    chk("rid", 32'(bus.o_rid), 32'(rq[0].id));
                    chk("rdata", 32'(bus.o_rdata), 32'(rq[0].data));
                    void'(rq.pop_front());
                end else begin
                    chk("rvalid_idle", 32'(bus.o_rvalid), 32'd0);
                end
                chk("busy", 32'(bus.o_busy), 32'(busy_exp[cyc]));
                if (prev_rst) begin
                    chk("rst_rid", 32'(bus.o_rid), 32'd0);
                    chk("rst_rdata", 32'(bus.o_rdata), 32'd0);
                    chk("rst_addr", 32'(bus.o_mem_addr), 32'd0);
                    chk("rst_din", 32'(bus.o_mem_din), 32'd0);
                end
            end
            prev_rst = rst;
        end
    end

    initial begin
        for (int a = 0; a < 64; a++) begin
            ram[a]     = DW'(a * 7 + 3);
            ref_mem[a] = DW'(a * 7 + 3);
        end
        for (int s = 0; s < RDL; s++) rd_pipe[s] = '0;
        bus.i_req   = '0;
        bus.i_we    = '0;
        bus.i_addr  = '0;
        bus.i_wdata = '0;
        for (int k = 0; k < N; k++) pend[k] = 1'b0;

        // Reset with everybody requesting, then round robin over reads at 8+k
        for (int k = 0; k < N; k++) set_req(k, 1'b0, AW'(8 + k), '0);
        drive_cycle(1'b1);
        drive_cycle(1'b1);
        repeat (7) drive_cycle(1'b0);

        // Write then read of the same address
        set_req(2, 1'b1, 6'h15, 8'hA5);
        drive_cycle(1'b0);
        set_req(1, 1'b0, 6'h15, '0);
        repeat (6) drive_cycle(1'b0);

        // Pointer fairness across the wrap
        set_req(3, 1'b0, 6'h03, '0);
        drive_cycle(1'b0);
        set_req(0, 1'b0, 6'h20, '0);
        set_req(3, 1'b0, 6'h23, '0);
        repeat (7) drive_cycle(1'b0);

        // Lone read surrounded by idle cycles
        set_req(1, 1'b0, 6'h2A, '0);
        repeat (8) drive_cycle(1'b0);

        // Reset while two reads are in flight
        set_req(0, 1'b0, 6'h10, '0);
        set_req(1, 1'b0, 6'h11, '0);
        drive_cycle(1'b0);
        drive_cycle(1'b0);
        drive_cycle(1'b1);
        for (int k = 0; k < N; k++) set_req(k, 1'b0, AW'(k), '0);
        repeat (8) drive_cycle(1'b0);

        // Random traffic with abandonments and occasional resets
        repeat (600) begin
            for (int k = 0; k < N; k++) begin
                if (pend[k]) begin
                    if ($urandom_range(0, 19) == 0) pend[k] = 1'b0;
                end else if ($urandom_range(0, 99) < 40) begin
                    set_req(k, 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
                end
            end
            drive_cycle($urandom_range(0, 99) == 0);
        end
        for (int k = 0; k < N; k++) pend[k] = 1'b0;
        repeat (10) drive_cycle(1'b0);

        @(posedge clk);
        #2;
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
